// File: rtl/ex_mem_stage.sv
// ---------------------------------------------------------------------------
// ex_mem_stage
// EX->MEM pipeline boundary. Captures the ALU result and the control bits of
// the executing instruction, resolves branches/jumps into a one-cycle PC
// redirect, and hands the instruction to MEM through a 2-entry skid buffer
// (main + skid register) with a ready/valid handshake on both sides.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous discard of all buffered instructions
//   ex_valid/ex_ready upstream handshake (ex_ready registered)
//   alu_res, zero_flag, rs2_data, pc, imm, rd_addr, reg_write, mem_read,
//   mem_write, br_type, jump
//                     EX instruction payload and control
//   mem_valid/mem_ready downstream handshake
//   mem_wb_data, mem_addr, mem_store_data, mem_rd, mem_reg_write,
//   mem_mem_read, mem_mem_write
//                     head entry toward MEM (driven from the main register)
//   redirect_valid, redirect_pc
//                     one-cycle redirect pulse and its target
// ---------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int unsigned XLEN = 32,
   parameter int unsigned RA_W = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            ex_valid,
   output logic            ex_ready,
   input  logic [XLEN-1:0] alu_res,
   input  logic            zero_flag,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] imm,
   input  logic [RA_W-1:0] rd_addr,
   input  logic            reg_write,
   input  logic            mem_read,
   input  logic            mem_write,
   input  logic [1:0]      br_type,
   input  logic            jump,
   output logic            mem_valid,
   input  logic            mem_ready,
   output logic [XLEN-1:0] mem_wb_data,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_store_data,
   output logic [RA_W-1:0] mem_rd,
   output logic            mem_reg_write,
   output logic            mem_mem_read,
   output logic            mem_mem_write,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc
);

   localparam logic [1:0] BR_BEQ = 2'b01;
   localparam logic [1:0] BR_BNE = 2'b10;
   localparam logic [1:0] BR_BLT = 2'b11;

   // One buffered instruction as seen by MEM
   typedef struct packed {
      logic [XLEN-1:0] wb_data;
      logic [XLEN-1:0] addr;
      logic [XLEN-1:0] store_data;
      logic [RA_W-1:0] rd;
      logic            reg_write;
      logic            mem_read;
      logic            mem_write;
   } entry_t;

   typedef enum logic [1:0] {
      S_EMPTY = 2'b00,
      S_ONE   = 2'b01,
      S_FULL  = 2'b10
   } state_t;

   state_t          state_q, state_nxt;
   entry_t          main_q, main_nxt;
   entry_t          skid_q, skid_nxt;
   entry_t          new_entry;
   logic            ex_ready_q, ex_ready_nxt;
   logic            mem_valid_q, mem_valid_nxt;
   logic            redir_q, redir_nxt;
   logic [XLEN-1:0] rpc_q, rpc_nxt;
   logic            accept;
   logic            pop;
   logic            taken;

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_EMPTY;
         main_q      <= '0;
         skid_q      <= '0;
         ex_ready_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         redir_q     <= 1'b0;
         rpc_q       <= '0;
      end else begin
         state_q     <= state_nxt;
         main_q      <= main_nxt;
         skid_q      <= skid_nxt;
         ex_ready_q  <= ex_ready_nxt;
         mem_valid_q <= mem_valid_nxt;
         redir_q     <= redir_nxt;
         rpc_q       <= rpc_nxt;
      end
   end

   // Next-state, buffer moves and branch resolution
   always_comb begin
      state_nxt     = state_q;
      main_nxt      = main_q;
      skid_nxt      = skid_q;
      redir_nxt     = 1'b0;
      rpc_nxt       = rpc_q;

      accept = ex_valid & ex_ready_q;
      pop    = mem_valid_q & mem_ready;

      taken = jump
            | ((br_type == BR_BEQ) &  zero_flag)
            | ((br_type == BR_BNE) & ~zero_flag)
            | ((br_type == BR_BLT) &  alu_res[0]);

      new_entry.wb_data    = jump ? (pc + XLEN'(4)) : alu_res;
      new_entry.addr       = alu_res;
      new_entry.store_data = rs2_data;
      new_entry.rd         = rd_addr;
      new_entry.reg_write  = reg_write;
      new_entry.mem_read   = mem_read;
      new_entry.mem_write  = mem_write;

      if (flush) begin
         // Flush wins over accept and pop; entries are simply invalidated
         state_nxt = S_EMPTY;
      end else begin
         unique case (state_q)
            S_EMPTY: begin
               if (accept) begin
                  main_nxt  = new_entry;
                  state_nxt = S_ONE;
               end
            end
            S_ONE: begin
               unique case ({accept, pop})
                  2'b11: main_nxt = new_entry;
                  2'b10: begin
                     skid_nxt  = new_entry;
                     state_nxt = S_FULL;
                  end
                  2'b01: state_nxt = S_EMPTY;
                  default: ;
               endcase
            end
            S_FULL: begin
               // ex_ready is low here, so only the pop can happen
               if (pop) begin
                  main_nxt  = skid_q;
                  state_nxt = S_ONE;
               end
            end
            default: state_nxt = S_EMPTY;
         endcase

         if (accept && taken) begin
            redir_nxt = 1'b1;
            rpc_nxt   = pc + imm;
         end
      end

      // Stall EX during the redirect cycle so wrong-path ops stay upstream
      ex_ready_nxt  = (state_nxt != S_FULL) & ~redir_nxt;
      mem_valid_nxt = (state_nxt != S_EMPTY);
   end

   assign ex_ready       = ex_ready_q;
   assign mem_valid      = mem_valid_q;
   assign mem_wb_data    = main_q.wb_data;
   assign mem_addr       = main_q.addr;
   assign mem_store_data = main_q.store_data;
   assign mem_rd         = main_q.rd;
   assign mem_reg_write  = main_q.reg_write;
   assign mem_mem_read   = main_q.mem_read;
   assign mem_mem_write  = main_q.mem_write;
   assign redirect_valid = redir_q;
   assign redirect_pc    = rpc_q;

endmodule
